// File: rtl/zion_rr_grant_idx.sv
`default_nettype none
// ============================================================================
// Module      : zion_rr_grant_idx
// Description : Round-robin arbiter that registers the winning requester as a
//               binary index (plus a constant offset) behind a one-entry
//               valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module zion_rr_grant_idx #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_BASE       = 0,
  parameter int WIDTH_IDX      = ($clog2(NUM_REQ + IDX_BASE) < 1) ? 1 : $clog2(NUM_REQ + IDX_BASE),
  parameter bit CHECK_ERR_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iClr,
  input  logic [NUM_REQ-1:0]   iReq,
  output logic                 oVld,
  input  logic                 iRdy,
  output logic [WIDTH_IDX-1:0] oIdx
);

  // Pointer width; NUM_REQ is at least 2 for any legal build.
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam longint IDX_SPAN = longint'(NUM_REQ) + longint'(IDX_BASE);

  // --------------------------------------------------------------------------
  // Parameter sanity: illegal builds are reported during elaboration.
  // $fatal is used when CHECK_ERR_EXIT is set so elaboration stops outright.
  // --------------------------------------------------------------------------
  generate
    if (NUM_REQ < 2) begin : g_err_num_req
      if (CHECK_ERR_EXIT) begin : g_exit
        $fatal(1, "zion_rr_grant_idx: NUM_REQ (%0d) must be at least 2", NUM_REQ);
      end else begin : g_report
        $error("zion_rr_grant_idx: NUM_REQ (%0d) must be at least 2", NUM_REQ);
      end
    end
    if ((WIDTH_IDX < 62) && ((64'sd1 <<< WIDTH_IDX) < IDX_SPAN)) begin : g_err_width
      if (CHECK_ERR_EXIT) begin : g_exit
        $fatal(1, "zion_rr_grant_idx: WIDTH_IDX (%0d) too small for NUM_REQ+IDX_BASE (%0d)",
               WIDTH_IDX, IDX_SPAN);
      end else begin : g_report
        $error("zion_rr_grant_idx: WIDTH_IDX (%0d) too small for NUM_REQ+IDX_BASE (%0d)",
               WIDTH_IDX, IDX_SPAN);
      end
    end
  endgenerate

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [WIDTH_IDX-1:0] idx_q, idx_d;

  logic                 w_found;
  logic [PTR_W-1:0]     w_grant;
  logic [PTR_W:0]       w_cand_wide;
  logic [PTR_W-1:0]     w_cand;
  logic                 w_load_slot;

  // Priority search: walk ptr, ptr+1, ... with explicit modulo wrap so the
  // candidate never reaches NUM_REQ for non-power-of-two sizes.
  always_comb begin
    w_found     = 1'b0;
    w_grant     = '0;
    w_cand_wide = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand_wide = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (w_cand_wide >= (PTR_W+1)'(NUM_REQ)) begin
        w_cand_wide = w_cand_wide - (PTR_W+1)'(NUM_REQ);
      end
      w_cand = w_cand_wide[PTR_W-1:0];
      if (!w_found && iReq[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Next-state: clear wins, then a load slot either captures a grant or
  // drains to EMPTY; a stalled FULL entry holds everything.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    w_load_slot = (state_q == EMPTY) || iRdy;
    if (iClr) begin
      state_d = EMPTY;
      ptr_d   = '0;
      idx_d   = '0;
    end else if (w_load_slot) begin
      if (w_found) begin
        state_d = FULL;
        idx_d   = WIDTH_IDX'(w_grant) + WIDTH_IDX'(IDX_BASE);
        ptr_d   = (w_grant == PTR_W'(NUM_REQ - 1)) ? '0 : (w_grant + PTR_W'(1));
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // State, pointer and output index registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  assign oVld = (state_q == FULL);
  assign oIdx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_zion_rr_grant_idx.sv
`default_nettype none
// ============================================================================
// Module      : tb_zion_rr_grant_idx
// Description : Self-checking bench for zion_rr_grant_idx: a vector table for
//               the 4-requester build plus hand sequences for the 5-requester
//               wrap case and the IDX_BASE=1 build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zion_rr_grant_idx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       rdy;
  logic [3:0] req_a;
  logic [4:0] req_b;
  logic [3:0] req_c;
  logic       vld_a, vld_b, vld_c;
  logic [1:0] idx_a;
  logic [2:0] idx_b;
  logic [2:0] idx_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  zion_rr_grant_idx #(.NUM_REQ(4), .IDX_BASE(0), .WIDTH_IDX(2)) u_a (
    .clk(clk), .rst_n(rst_n), .iClr(clr), .iReq(req_a),
    .oVld(vld_a), .iRdy(rdy), .oIdx(idx_a)
  );

  zion_rr_grant_idx #(.NUM_REQ(5), .IDX_BASE(0), .WIDTH_IDX(3)) u_b (
    .clk(clk), .rst_n(rst_n), .iClr(clr), .iReq(req_b),
    .oVld(vld_b), .iRdy(rdy), .oIdx(idx_b)
  );

  zion_rr_grant_idx #(.NUM_REQ(4), .IDX_BASE(1), .WIDTH_IDX(3)) u_c (
    .clk(clk), .rst_n(rst_n), .iClr(clr), .iReq(req_c),
    .oVld(vld_c), .iRdy(rdy), .oIdx(idx_c)
  );

  typedef struct {
    string      name;
    int         sel;
    logic       vld;
    logic [7:0] idx;
  } exp_t;

  typedef struct {
    string      name;
    logic       clr;
    logic [3:0] req;
    logic       rdy;
    logic       vld;
    logic [7:0] idx;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic observe(input int sel, output logic v, output logic [7:0] i);
    case (sel)
      0:       begin v = vld_a; i = {6'b0, idx_a}; end
      1:       begin v = vld_b; i = {5'b0, idx_b}; end
      default: begin v = vld_c; i = {5'b0, idx_c}; end
    endcase
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string name, input logic c, input logic [3:0] ra,
                      input logic [4:0] rb, input logic [3:0] rc, input logic r,
                      input int sel, input logic ev, input logic [7:0] ei);
    exp_t       e;
    logic       av;
    logic [7:0] ai;
    clr   = c;
    req_a = ra;
    req_b = rb;
    req_c = rc;
    rdy   = r;
    sb_q.push_back('{name, sel, ev, ei});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    observe(e.sel, av, ai);
    check({e.name, ".vld"}, {7'b0, av}, {7'b0, e.vld});
    check({e.name, ".idx"}, ai, e.idx);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // name, clr, req, rdy, exp vld, exp idx (4-requester, base 0)
    tbl.push_back('{"rr0",      1'b0, 4'b1111, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{"rr1",      1'b0, 4'b1111, 1'b1, 1'b1, 8'd1});
    tbl.push_back('{"rr2",      1'b0, 4'b1111, 1'b1, 1'b1, 8'd2});
    tbl.push_back('{"rr3",      1'b0, 4'b1111, 1'b1, 1'b1, 8'd3});
    tbl.push_back('{"rr4",      1'b0, 4'b1111, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{"rr5",      1'b0, 4'b1111, 1'b1, 1'b1, 8'd1});
    tbl.push_back('{"rr6",      1'b0, 4'b1111, 1'b1, 1'b1, 8'd2});
    tbl.push_back('{"rr7",      1'b0, 4'b1111, 1'b1, 1'b1, 8'd3});
    tbl.push_back('{"grant2",   1'b0, 4'b0100, 1'b1, 1'b1, 8'd2});
    tbl.push_back('{"stall_a",  1'b0, 4'b1111, 1'b0, 1'b1, 8'd2});
    tbl.push_back('{"stall_b",  1'b0, 4'b0000, 1'b0, 1'b1, 8'd2});
    tbl.push_back('{"stall_c",  1'b0, 4'b0001, 1'b0, 1'b1, 8'd2});
    tbl.push_back('{"after_st", 1'b0, 4'b1111, 1'b1, 1'b1, 8'd3});
    tbl.push_back('{"drain",    1'b0, 4'b0000, 1'b1, 1'b0, 8'd3});
    tbl.push_back('{"idle",     1'b0, 4'b0000, 1'b0, 1'b0, 8'd3});
    tbl.push_back('{"empty_ld", 1'b0, 4'b0010, 1'b0, 1'b1, 8'd1});
    tbl.push_back('{"clear",    1'b1, 4'b1111, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{"alt0",     1'b0, 4'b1010, 1'b1, 1'b1, 8'd1});
    tbl.push_back('{"alt1",     1'b0, 4'b1010, 1'b1, 1'b1, 8'd3});
    tbl.push_back('{"alt2",     1'b0, 4'b1010, 1'b1, 1'b1, 8'd1});
    tbl.push_back('{"single0",  1'b0, 4'b0100, 1'b1, 1'b1, 8'd2});
    tbl.push_back('{"single1",  1'b0, 4'b0100, 1'b1, 1'b1, 8'd2});

    rst_n = 1'b0;
    clr   = 1'b0;
    rdy   = 1'b0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.vld_a", {7'b0, vld_a}, 8'd0);
    check("reset.idx_a", {6'b0, idx_a}, 8'd0);
    check("reset.vld_b", {7'b0, vld_b}, 8'd0);
    check("reset.vld_c", {7'b0, vld_c}, 8'd0);
    rst_n = 1'b1;

    // Table-driven run on the 4-requester, base-0 instance.
    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].name, tbl[n].clr, tbl[n].req, 5'b0, 4'b0, tbl[n].rdy, 0,
           tbl[n].vld, tbl[n].idx);
    end

    // Asynchronous reset while FULL: outputs clear with no clock edge.
    rst_n = 1'b0;
    #2;
    check("async_rst.vld", {7'b0, vld_a}, 8'd0);
    check("async_rst.idx", {6'b0, idx_a}, 8'd0);
    #2;
    rst_n = 1'b1;
    // Pointer must be back at 0 (it was 3 before reset).
    step("post_rst", 1'b0, 4'b1111, 5'b0, 4'b0, 1'b1, 0, 1'b1, 8'd0);

    // Five requesters: 0 and 4 alternate, pointer wraps 4 -> 0.
    step("wrap0", 1'b0, 4'b0, 5'b10001, 4'b0, 1'b1, 1, 1'b1, 8'd0);
    step("wrap1", 1'b0, 4'b0, 5'b10001, 4'b0, 1'b1, 1, 1'b1, 8'd4);
    step("wrap2", 1'b0, 4'b0, 5'b10001, 4'b0, 1'b1, 1, 1'b1, 8'd0);
    step("wrap3", 1'b0, 4'b0, 5'b10001, 4'b0, 1'b1, 1, 1'b1, 8'd4);
    step("wrap4", 1'b0, 4'b0, 5'b11111, 4'b0, 1'b1, 1, 1'b1, 8'd0);
    step("wrap5", 1'b0, 4'b0, 5'b11111, 4'b0, 1'b1, 1, 1'b1, 8'd1);

    // Offset build: requester 2 -> 3, requester 3 -> 4 (no truncation).
    step("base0", 1'b0, 4'b0, 5'b0, 4'b0100, 1'b1, 2, 1'b1, 8'd3);
    step("base1", 1'b0, 4'b0, 5'b0, 4'b0000, 1'b1, 2, 1'b0, 8'd3);
    step("base2", 1'b0, 4'b0, 5'b0, 4'b1000, 1'b1, 2, 1'b1, 8'd4);
    step("base3", 1'b0, 4'b0, 5'b0, 4'b0001, 1'b0, 2, 1'b1, 8'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
